mkgauss_stream: RTL and testbench
=================================

Name: mkgauss_stream

Overview:
- Parametrised successor to the single-mode Falcon Gaussian coefficient sampler.
- Generates one full polynomial of 2^logn small signed coefficients per start command. logn is selectable at run time (not fixed at elaboration).
- Consumes 128-bit words from the upstream PRNG. Buffers coefficients in an internal FIFO and delivers them through a valid/ready output with backpressure.
- Sits between the SHAKE-based PRNG and the keygen NTT/f,g storage.

Parameters:
- LOGN_MIN, 8, smallest accepted runtime logn
- LOGN_MAX, 10, largest accepted runtime logn
- VAL_W, 8, coefficient width; must cover ±26·2^(10−LOGN_MIN)
- FIFO_DEPTH, 4, output FIFO entries (power of two, ≥2)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- start  in  1  begin a polynomial; honoured only in IDLE
- logn  in  4  polynomial degree exponent, latched on an accepted start
- busy  out  1  high in RUN or DRAIN
- err  out  1  1-cycle pulse: start received with logn outside [LOGN_MIN, LOGN_MAX]; start is otherwise ignored
- done  out  1  1-cycle pulse after the last coefficient is popped
- rng_valid  in  1  rng word available
- rng  in  128  random word: [127:64] first u64, [63:0] second u64
- rng_extract  out  1  word consumed this cycle; asserted only when rng_valid=1
- val_valid  out  1  FIFO non-empty
- val_ready  in  1  downstream accepts
- val  out  VAL_W  signed coefficient at FIFO head

Behaviour:
- Clocking and reset
  - Single clock domain; clk only.
  - rst is synchronous and active-high. It has priority over all other inputs and may be applied mid-operation.
  - On rst: state=IDLE, FIFO flushed, accumulators and counters cleared; busy=err=done=rng_extract=val_valid=0, val=0.
- Per-sample function (Falcon mkgauss, one rng word → one sample s in [−26, 26])
  - neg=rng[127]; r0=rng[126:64]; r1=rng[62:0].
  - f=(r0<T[0]).
  - For k=1..26 in order: t=(r1≥T[k]); if t&!f then v=k; f|=t.
  - s = neg ? −v : v.
  - T is the 27-entry, 63-bit gauss_1024_12289 table.
- Coefficient formation
  - g = 2^(10−logn) samples are summed into one coefficient.
  - Sum is sign-extended to VAL_W; no saturation is needed by construction.
- FSM: IDLE → RUN on a valid start.
  - RUN → DRAIN when coefficient 2^logn has had its last sample accepted.
  - DRAIN → IDLE when FIFO is empty and the pipeline is idle; done pulses on that transition.
  - start in RUN or DRAIN: ignored, no err.
- Pipeline
  - Accepted word at edge t.
  - Sample registered at t+1.
  - Accumulated; the coefficient completing at t+1 is written to the FIFO at t+2.
  - First val_valid no earlier than t+3 after the final word of the first group.
- Credit rule
  - rng_extract = RUN & rng_valid & (group in progress | fifo_count + pending < FIFO_DEPTH).
  - pending = coefficients started but not yet written.
  - FIFO never overflows.
  - No word is extracted after the 2^logn-th coefficient is complete.
- FIFO
  - Simultaneous push and pop when full or when empty are both legal.
  - val is stable while val_valid & !val_ready.
  - Pop occurs when val_valid & val_ready.
- Coefficient counter
  - Counts 0..2^logn−1 and wraps to 0 at end of polynomial.
  - Sample-in-group counter counts 0..g−1.

Decomposition:
- mkgauss_pkg
  - GAUSS_TBL (27×63-bit constants).
  - GAUSS_TBL_N=27, GAUSS_ENT_W=63.
  - FSM state enum {IDLE, RUN, DRAIN}.
  - Sample width constant SAMP_W=6.
- Sub-module gauss_sample_core
  - Combinational 128-bit → signed 6-bit sample, using GAUSS_TBL.
  - Instantiated once; its output is registered in mkgauss_stream.

Test Plan:
- rng held at all-zeros, logn=10, val_ready=1, start → 1024 words extracted, 1024 coefficients of value 0, then one done pulse, busy drops.
- rng all-ones; logn=9 → 1024 words extracted and 512 coefficients of value −2. logn=8 → 1024 words extracted and 256 coefficients of value −4.
- Single rng word with [127:64]=0, r1=T[1]−1, logn=10 → coefficient 0; r1=T[1] with r0≥T[0] → coefficient +1.
- logn=10, val_ready=0, FIFO_DEPTH=4, all-ones rng → exactly 4 words extracted, then rng_extract stays 0. Raise val_ready → four −1 values popped in order and extraction resumes.
- start with logn=7 → err pulse, busy=0, no extraction. start during RUN → ignored.
- rst asserted mid-RUN with 2 FIFO entries → next cycle val_valid=0, busy=0. A fresh start produces a full polynomial.

Source files
------------

// File: rtl/mkgauss_pkg.sv
// mkgauss_pkg: shared constants, Falcon gauss_1024_12289 table and FSM states
package mkgauss_pkg;
  localparam int GAUSS_TBL_N = 27;
  localparam int GAUSS_ENT_W = 63;
  localparam int SAMP_W = 6;
  localparam int FALCON_LOGN = 10;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  localparam logic [GAUSS_ENT_W-1:0] GAUSS_TBL [GAUSS_TBL_N] = '{
    63'd1283868770400643928, 63'd6416574995475331444, 63'd4078260278032692663,
    63'd2353523259288686585, 63'd1227179971273316331, 63'd575931623374121527,
    63'd242543240509105209,  63'd91437049221049666,   63'd30799446349977173,
    63'd9255276791179340,    63'd2478152334826140,    63'd590642893610164,
    63'd125206034929641,     63'd23590435911403,      63'd3948334035941,
    63'd586753615614,        63'd77391054539,         63'd9056793210,
    63'd940121950,           63'd86539696,            63'd7062824,
    63'd510971,              63'd32764,               63'd1862,
    63'd94,                  63'd4,                   63'd0
  };
endpackage

// File: rtl/gauss_sample_core.sv
// gauss_sample_core: combinational Falcon mkgauss sample from one 128-bit rng word
module gauss_sample_core import mkgauss_pkg::*; (
  input  logic [127:0]              rng,
  output logic signed [SAMP_W-1:0]  samp
);
  logic       f;
  logic       t;
  logic [4:0] v;
  always_comb begin
    f = rng[126:64] < GAUSS_TBL[0];
    t = 1'b0;
    v = '0;
    for (int k = 1; k < GAUSS_TBL_N; k++) begin
      t = rng[62:0] >= GAUSS_TBL[k];
      v = (t && !f) ? 5'(k) : v;
      f = f | t;
    end
    samp = rng[127] ? -$signed({1'b0, v}) : $signed({1'b0, v});
  end
endmodule

// File: rtl/mkgauss_stream.sv
// mkgauss_stream: runtime-logn Gaussian polynomial sampler with credit-gated output FIFO
module mkgauss_stream import mkgauss_pkg::*; #(
  parameter int LOGN_MIN   = 8,
  parameter int LOGN_MAX   = 10,
  parameter int VAL_W      = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              logn,
  output logic                    busy,
  output logic                    err,
  output logic                    done,
  input  logic                    rng_valid,
  input  logic [127:0]            rng,
  output logic                    rng_extract,
  output logic                    val_valid,
  input  logic                    val_ready,
  output logic signed [VAL_W-1:0] val
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int GW = FALCON_LOGN - LOGN_MIN + 1;
  state_t state, state_n;
  logic [3:0] logn_q;
  logic [LOGN_MAX-1:0] coef_cnt;
  logic [GW-1:0] samp_cnt;
  logic [AW:0] fifo_cnt, pend;
  logic [AW-1:0] wptr, rptr;
  logic signed [VAL_W-1:0] mem [FIFO_DEPTH];
  logic signed [SAMP_W-1:0] samp, samp_q;
  logic signed [VAL_W-1:0] acc, coef_q, sum;
  logic samp_v, samp_last, coef_v;
  logic bad, accept, grp_first, grp_last, poly_last, pop, drained;
  gauss_sample_core u_core (.rng(rng), .samp(samp));
  assign bad = logn < 4'(LOGN_MIN) || logn > 4'(LOGN_MAX);
  assign accept = state == IDLE && start && !bad;
  assign grp_first = samp_cnt == '0;
  assign grp_last = samp_cnt == GW'((32'd1 << (FALCON_LOGN - 32'(logn_q))) - 32'd1);
  assign poly_last = coef_cnt == LOGN_MAX'((32'd1 << logn_q) - 32'd1);
  // a new group may only start if every coefficient in flight already has a FIFO slot
  assign rng_extract = state == RUN && rng_valid && (!grp_first || fifo_cnt + pend < (AW+1)'(FIFO_DEPTH));
  assign sum = acc + {{(VAL_W-SAMP_W){samp_q[SAMP_W-1]}}, samp_q};
  assign val_valid = fifo_cnt != '0;
  assign val = val_valid ? mem[rptr] : '0;
  assign pop = val_valid && val_ready;
  assign drained = pend == '0 && !val_valid;
  assign done = state == DRAIN && drained;
  assign busy = state != IDLE;
  always_comb begin
    state_n = state;
    if (accept) state_n = RUN;
    else if (state == RUN && rng_extract && grp_last && poly_last) state_n = DRAIN;
    else if (done) state_n = IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      err <= 1'b0;
      logn_q <= '0;
      coef_cnt <= '0;
      samp_cnt <= '0;
      samp_v <= 1'b0;
      samp_last <= 1'b0;
      samp_q <= '0;
      acc <= '0;
      coef_v <= 1'b0;
      coef_q <= '0;
      pend <= '0;
      fifo_cnt <= '0;
      wptr <= '0;
      rptr <= '0;
    end else begin
      state <= state_n;
      err <= state == IDLE && start && bad;
      if (accept) logn_q <= logn;
      if (rng_extract) begin
        samp_cnt <= grp_last ? '0 : samp_cnt + 1'b1;
        if (grp_last) coef_cnt <= poly_last ? '0 : coef_cnt + 1'b1;
      end
      samp_v <= rng_extract;
      samp_q <= samp;
      samp_last <= grp_last;
      if (samp_v) acc <= samp_last ? '0 : sum;
      coef_v <= samp_v && samp_last;
      coef_q <= sum;
      pend <= pend + (AW+1)'(rng_extract && grp_first) - (AW+1)'(coef_v);
      fifo_cnt <= fifo_cnt + (AW+1)'(coef_v) - (AW+1)'(pop);
      if (coef_v) begin
        mem[wptr] <= coef_q;
        wptr <= wptr + 1'b1;
      end
      if (pop) rptr <= rptr + 1'b1;
    end
  end
endmodule

// File: tb/tb_mkgauss_stream.sv
// tb_mkgauss_stream: table vectors, random scoreboard and corner sequences for mkgauss_stream
module tb_mkgauss_stream;
  localparam longint unsigned T [27] = '{
    64'd1283868770400643928, 64'd6416574995475331444, 64'd4078260278032692663,
    64'd2353523259288686585, 64'd1227179971273316331, 64'd575931623374121527,
    64'd242543240509105209,  64'd91437049221049666,   64'd30799446349977173,
    64'd9255276791179340,    64'd2478152334826140,    64'd590642893610164,
    64'd125206034929641,     64'd23590435911403,      64'd3948334035941,
    64'd586753615614,        64'd77391054539,         64'd9056793210,
    64'd940121950,           64'd86539696,            64'd7062824,
    64'd510971,              64'd32764,               64'd1862,
    64'd94,                  64'd4,                   64'd0
  };
  logic clk = 1'b0;
  logic rst, start, busy, err, done, rng_valid, rng_extract, val_valid, val_ready;
  logic [3:0] logn;
  logic [127:0] rng;
  logic signed [7:0] val;
  mkgauss_stream dut (
    .clk(clk), .rst(rst), .start(start), .logn(logn), .busy(busy), .err(err), .done(done),
    .rng_valid(rng_valid), .rng(rng), .rng_extract(rng_extract),
    .val_valid(val_valid), .val_ready(val_ready), .val(val)
  );
  always #5 clk = ~clk;

  typedef struct {
    int           ln;
    logic [127:0] w;
    int           coef;
  } vec_t;
  vec_t vecs[7];

  int checks = 0, errors = 0;
  int rng_mode, pv, pr;
  logic [127:0] fixed_word;
  int mlogn, macc, mcnt, words, pops, n_done, n_err;
  int exp_q[$];
  int tbl_on, tbl_coef, tbl_bad;
  logic prev_stall;
  logic signed [7:0] prev_val;

  task automatic chk(input string name, input longint got, input longint want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, want);
    end
  endtask

  function automatic int ref_samp(input logic [127:0] w);
    longint unsigned r0 = {1'b0, w[126:64]};
    longint unsigned r1 = {1'b0, w[62:0]};
    int v = 0;
    if (r0 >= T[0])
      for (int k = 1; k < 27 && v == 0; k++)
        if (r1 >= T[k]) v = k;
    return w[127] ? -v : v;
  endfunction

  task automatic cyc();
    rng = (rng_mode == 1) ? {$urandom, $urandom, $urandom, $urandom} : fixed_word;
    rng_valid = $urandom_range(99) < pv;
    val_ready = $urandom_range(99) < pr;
    #1;
    if (prev_stall) begin
      chk("hold_valid", val_valid, 1);
      chk("hold_val", val, prev_val);
    end
    prev_stall = val_valid && !val_ready;
    prev_val = val;
    if (val_valid && val_ready) begin
      pops++;
      if (tbl_on != 0 && val != tbl_coef) tbl_bad++;
      chk("exp_nonempty", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) chk("coef", val, exp_q.pop_front());
    end
    if (rng_extract) begin
      chk("extract_valid", rng_valid, 1);
      words++;
      macc += ref_samp(rng);
      mcnt++;
      if (mcnt == (1 << (10 - mlogn))) begin
        exp_q.push_back(macc);
        macc = 0;
        mcnt = 0;
      end
    end
    if (done) n_done++;
    if (err) n_err++;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic begin_poly(input int ln);
    mlogn = ln; macc = 0; mcnt = 0; words = 0; pops = 0; n_done = 0; n_err = 0;
    exp_q.delete();
    start = 1'b1;
    logn = ln[3:0];
  endtask

  task automatic finish_poly(input int ln, input int budget);
    int n = 0;
    while (n_done == 0 && n < budget) begin
      cyc();
      n++;
    end
    repeat (3) cyc();
    chk("poly_done_once", n_done, 1);
    chk("poly_words", words, 1024);
    chk("poly_coefs", pops, 1 << ln);
    chk("poly_leftover", exp_q.size(), 0);
    chk("poly_busy_after", busy, 0);
    chk("poly_no_err", n_err, 0);
  endtask

  initial begin
    vecs[0] = '{10, 128'd0, 0};
    vecs[1] = '{9, {128{1'b1}}, -2};
    vecs[2] = '{8, {128{1'b1}}, -4};
    vecs[3] = '{10, {64'd0, 64'(T[1] - 1)}, 0};
    vecs[4] = '{10, {64'h7FFF_FFFF_FFFF_FFFF, 64'(T[1])}, 1};
    vecs[5] = '{8, {64'h7FFF_FFFF_FFFF_FFFF, 64'h7FFF_FFFF_FFFF_FFFF}, 4};
    vecs[6] = '{10, {64'hFFFF_FFFF_FFFF_FFFF, 64'(T[1] - 1)}, -2};
    rst = 1'b1; start = 1'b0; logn = '0; rng_valid = 1'b0; rng = '0; val_ready = 1'b0;
    prev_stall = 1'b0; tbl_on = 0; tbl_coef = 0; tbl_bad = 0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_done", done, 0);
    chk("rst_extract", rng_extract, 0);
    chk("rst_val_valid", val_valid, 0);
    chk("rst_val", val, 0);
    rst = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 7; i++) begin
      rng_mode = 0; fixed_word = vecs[i].w; pv = 100; pr = 100;
      tbl_on = 1; tbl_coef = vecs[i].coef; tbl_bad = 0;
      begin_poly(vecs[i].ln);
      finish_poly(vecs[i].ln, 5000);
      chk("vec_all_coef", tbl_bad, 0);
    end
    tbl_on = 0;

    for (int ln = 8; ln <= 10; ln++) begin
      rng_mode = 1; pv = 70; pr = 60;
      begin_poly(ln);
      finish_poly(ln, 8000);
    end

    rng_mode = 1; pv = 80; pr = 50;
    begin_poly(9);
    repeat (100) cyc();
    start = 1'b1; logn = 4'd7; cyc();
    start = 1'b1; logn = 4'd8; cyc();
    finish_poly(9, 8000);

    n_err = 0; words = 0;
    start = 1'b1; logn = 4'd7; repeat (5) cyc();
    chk("err_lo_pulse", n_err, 1);
    chk("err_lo_busy", busy, 0);
    chk("err_lo_words", words, 0);
    n_err = 0;
    start = 1'b1; logn = 4'd11; repeat (5) cyc();
    chk("err_hi_pulse", n_err, 1);
    chk("err_hi_busy", busy, 0);

    rng_mode = 0; fixed_word = {128{1'b1}}; pv = 100; pr = 0;
    begin_poly(10);
    repeat (20) cyc();
    chk("bp_words", words, 4);
    chk("bp_extract_low", rng_extract, 0);
    chk("bp_val_valid", val_valid, 1);
    pr = 100;
    repeat (4) cyc();
    chk("bp_pops", pops, 4);
    chk("bp_resumed", words > 4, 1);
    finish_poly(10, 5000);

    rng_mode = 0; fixed_word = {128{1'b1}}; pv = 100; pr = 0;
    begin_poly(10);
    repeat (3) cyc();
    pv = 0;
    repeat (5) cyc();
    chk("rst_mid_words", words, 2);
    chk("rst_mid_valid", val_valid, 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_mid_val_valid", val_valid, 0);
    chk("rst_mid_busy", busy, 0);
    chk("rst_mid_val", val, 0);
    @(negedge clk);
    prev_stall = 1'b0;
    rng_mode = 1; pv = 70; pr = 70;
    begin_poly(8);
    finish_poly(8, 8000);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
